// File: rtl/rv_hazard_pkg.sv
// Shared types for the decode-stage hazard controller.
// Holds the shadow-pipeline entry type, its idle value and the forwarding-select type.
package rv_hazard_pkg;

    // Widest register index supported (RV32I). RV32E builds zero-extend 4-bit indices into it.
    localparam int unsigned HZ_REG_ADDR_W = 5;

    // Forwarding select for one source operand. At most one bit set; all zero = register file.
    typedef struct packed {
        logic alu2;
        logic write;
        logic wr_back;
    } ctrl_rs_bp_t;

    // One shadow-pipeline slot: who will write which register, and whether it is a load.
    typedef struct packed {
        logic                     valid;
        logic [HZ_REG_ADDR_W-1:0] rd;
        logic                     load;
    } hz_stage_t;

    localparam hz_stage_t HZ_STAGE_IDLE = '{valid: 1'b0, rd: '0, load: 1'b0};

    // Build a shadow entry; writes to x0 are never tracked so they can never match.
    function automatic hz_stage_t hz_make_entry(input logic                     rd_we,
                                                input logic [HZ_REG_ADDR_W-1:0] rd,
                                                input logic                     load);
        hz_stage_t entry;
        entry.valid = rd_we && (rd != '0);
        entry.rd    = rd;
        entry.load  = load;
        return entry;
    endfunction

endpackage

// File: rtl/rv_hazard_match.sv
// Compares one decode-stage source register against the three shadow stages.
// Produces a youngest-first forwarding select, a load-in-ALU2 hit and an any-stage hit.
module rv_hazard_match
    import rv_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_rs_used,
    input  hz_stage_t             i_alu2,
    input  hz_stage_t             i_write,
    input  hz_stage_t             i_wr_back,
    output ctrl_rs_bp_t           o_bp,
    output logic                  o_load_hit,
    output logic                  o_any_hit
);

    logic [HZ_REG_ADDR_W-1:0] rs_ext;
    logic                     rs_live;
    logic                     hit_alu2;
    logic                     hit_write;
    logic                     hit_wr_back;

    assign rs_ext  = HZ_REG_ADDR_W'(i_rs);
    // x0 reads are constant zero and never need forwarding.
    assign rs_live = i_rs_used && (rs_ext != '0);

    assign hit_alu2    = rs_live && i_alu2.valid    && (i_alu2.rd    == rs_ext);
    assign hit_write   = rs_live && i_write.valid   && (i_write.rd   == rs_ext);
    assign hit_wr_back = rs_live && i_wr_back.valid && (i_wr_back.rd == rs_ext);

    // Youngest producer wins: ALU2 over WRITE over WR_BACK.
    always_comb begin
        o_bp = '0;
        if (hit_alu2) begin
            o_bp.alu2 = 1'b1;
        end else if (hit_write) begin
            o_bp.write = 1'b1;
        end else if (hit_wr_back) begin
            o_bp.wr_back = 1'b1;
        end
    end

    // A load sitting in ALU2 has no result yet, so only that case is a forwarding hazard.
    assign o_load_hit = hit_alu2 && i_alu2.load;
    assign o_any_hit  = hit_alu2 || hit_write || hit_wr_back;

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Decode-stage hazard controller: shadow pipeline of destination registers for the
// ALU2/WRITE/WR_BACK stages, operand forwarding selects and the decode stall.
// Build option RV_HAZARD_BYPASS_EN: when defined, operands are forwarded and only load-use
// stalls; when undefined, forwarding selects are zero and decode stalls until every
// matching producer has left WR_BACK.
module rv_hazard_ctrl
    import rv_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_rs1_used,
    input  logic                  i_rs2_used,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_issue_rd_we,
    input  logic                  i_issue_load,
    input  logic                  i_pipe_stall,
    input  logic                  i_flush,
    output ctrl_rs_bp_t           o_rs1_bp,
    output ctrl_rs_bp_t           o_rs2_bp,
    output logic                  o_stall
);

    hz_stage_t   alu2_q, alu2_d;
    hz_stage_t   write_q, write_d;
    hz_stage_t   wr_back_q, wr_back_d;
    hz_stage_t   issue_entry;
    logic        issue_go;
    logic        stall;

    ctrl_rs_bp_t rs1_bp;
    ctrl_rs_bp_t rs2_bp;
    logic        rs1_load_hit;
    logic        rs2_load_hit;
    logic        rs1_any_hit;
    logic        rs2_any_hit;

    assign issue_entry = hz_make_entry(i_issue_rd_we, HZ_REG_ADDR_W'(i_issue_rd), i_issue_load);

    // A stalled or flushed instruction leaves a bubble behind it in ALU2.
    assign issue_go = i_issue_valid && !stall && !i_flush;

    // Shadow pipeline next state: shift one stage per advancing cycle, hold on pipeline freeze.
    always_comb begin
        alu2_d    = alu2_q;
        write_d   = write_q;
        wr_back_d = wr_back_q;
        if (!i_pipe_stall) begin
            wr_back_d = write_q;
            write_d   = alu2_q;
            alu2_d    = issue_go ? issue_entry : HZ_STAGE_IDLE;
        end
    end

    // Shadow pipeline registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            alu2_q    <= HZ_STAGE_IDLE;
            write_q   <= HZ_STAGE_IDLE;
            wr_back_q <= HZ_STAGE_IDLE;
        end else begin
            alu2_q    <= alu2_d;
            write_q   <= write_d;
            wr_back_q <= wr_back_d;
        end
    end

    rv_hazard_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_match_rs1 (
        .i_rs       (i_rs1),
        .i_rs_used  (i_rs1_used),
        .i_alu2     (alu2_q),
        .i_write    (write_q),
        .i_wr_back  (wr_back_q),
        .o_bp       (rs1_bp),
        .o_load_hit (rs1_load_hit),
        .o_any_hit  (rs1_any_hit)
    );

    rv_hazard_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_match_rs2 (
        .i_rs       (i_rs2),
        .i_rs_used  (i_rs2_used),
        .i_alu2     (alu2_q),
        .i_write    (write_q),
        .i_wr_back  (wr_back_q),
        .o_bp       (rs2_bp),
        .o_load_hit (rs2_load_hit),
        .o_any_hit  (rs2_any_hit)
    );

`ifdef RV_HAZARD_BYPASS_EN
    // Only a load still in ALU2 cannot be forwarded; the bubble moves it to WRITE next cycle.
    assign stall    = i_issue_valid && (rs1_load_hit || rs2_load_hit);
    assign o_rs1_bp = rs1_bp;
    assign o_rs2_bp = rs2_bp;

    logic unused_any_hit;
    assign unused_any_hit = ^{rs1_any_hit, rs2_any_hit};
`else
    // No forwarding paths: wait until the producer has retired past WR_BACK.
    assign stall    = i_issue_valid && (rs1_any_hit || rs2_any_hit);
    assign o_rs1_bp = '0;
    assign o_rs2_bp = '0;

    logic unused_bp;
    assign unused_bp = ^{rs1_bp, rs2_bp, rs1_load_hit, rs2_load_hit};
`endif

    assign o_stall = stall;

    // Structural sanity checks on the outputs.
    a_rs1_bp_onehot : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_rs1_bp));
    a_rs2_bp_onehot : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_rs2_bp));
    a_stall_needs_issue : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_stall |-> i_issue_valid);
    a_hold_on_freeze : assert property (@(posedge i_clk) disable iff (!i_reset_n)
        i_pipe_stall |=> ($stable(alu2_q) && $stable(write_q) && $stable(wr_back_q)));

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed scenarios plus randomized traffic,
// compared against a behavioural model of the in-flight producers.
module tb_rv_hazard_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [4:0] i_rs1 = '0, i_rs2 = '0, i_issue_rd = '0;
    logic       i_rs1_used = 1'b0, i_rs2_used = 1'b0, i_issue_valid = 1'b0;
    logic       i_issue_rd_we = 1'b0, i_issue_load = 1'b0, i_pipe_stall = 1'b0, i_flush = 1'b0;
    logic [2:0] o_rs1_bp, o_rs2_bp;
    logic       o_stall;
    logic [6:0] obs;

    always #5 i_clk = ~i_clk;

    rv_hazard_ctrl #(
        .REG_ADDR_W (5)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_rs1_used    (i_rs1_used),
        .i_rs2_used    (i_rs2_used),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_issue_rd_we (i_issue_rd_we),
        .i_issue_load  (i_issue_load),
        .i_pipe_stall  (i_pipe_stall),
        .i_flush       (i_flush),
        .o_rs1_bp      (o_rs1_bp),
        .o_rs2_bp      (o_rs2_bp),
        .o_stall       (o_stall)
    );

    assign obs = {o_stall, o_rs1_bp, o_rs2_bp};

    typedef struct {
        int rs1; int rs2; bit u1; bit u2; bit v; int rd; bit we; bit ld; bit ps; bit fl;
    } vec_t;

    // Model: producers in flight, index = age in stages after decode (0 = ALU2, 2 = WR_BACK).
    bit m_v [3];
    int m_rd[3];
    bit m_ld[3];

    vec_t       cur;
    bit         exp_stall;
    logic [6:0] exp_all;
    int         vectors = 0;
    int         errors  = 0;

    function automatic vec_t mk(int rs1, int rs2, bit u1, bit u2, bit v, int rd, bit we,
                                bit ld, bit ps, bit fl);
        vec_t x;
        x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2; x.v = v;
        x.rd = rd; x.we = we; x.ld = ld; x.ps = ps; x.fl = fl;
        return x;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0; m_rd[k] = 0; m_ld[k] = 1'b0;
        end
    endfunction

    // Age of the youngest in-flight producer of rs, or -1 if none.
    function automatic int youngest(int rs, bit used);
        for (int k = 0; k < 3; k++) begin
            if (used && rs != 0 && m_v[k] && m_rd[k] == rs) return k;
        end
        return -1;
    endfunction

    // Drive one decode cycle and derive the expected outputs from the model.
    task automatic apply(input vec_t x);
        int a1, a2;
        logic [2:0] b1, b2;
        @(negedge i_clk);
        i_rs1 = 5'(x.rs1); i_rs2 = 5'(x.rs2); i_rs1_used = x.u1; i_rs2_used = x.u2;
        i_issue_valid = x.v; i_issue_rd = 5'(x.rd); i_issue_rd_we = x.we;
        i_issue_load = x.ld; i_pipe_stall = x.ps; i_flush = x.fl;
        cur = x;
        #1;
        a1 = youngest(x.rs1, x.u1);
        a2 = youngest(x.rs2, x.u2);
`ifdef RV_HAZARD_BYPASS_EN
        exp_stall = x.v && m_ld[0] && (a1 == 0 || a2 == 0);
        b1 = (a1 < 0) ? 3'b000 : (3'b100 >> a1);
        b2 = (a2 < 0) ? 3'b000 : (3'b100 >> a2);
`else
        exp_stall = x.v && (a1 >= 0 || a2 >= 0);
        b1 = 3'b000;
        b2 = 3'b000;
`endif
        exp_all = {exp_stall, b1, b2};
    endtask

    // Clock edge: producers age by one stage unless the pipeline is frozen.
    task automatic tick();
        @(posedge i_clk);
        if (!cur.ps) begin
            for (int k = 2; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[0]  = cur.v && !exp_stall && !cur.fl && cur.we && cur.rd != 0;
            m_rd[0] = cur.rd;
            m_ld[0] = cur.ld;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            apply(idle());
            tick();
        end
    endtask

    task automatic test_reset();
        model_clear();
        i_rs1 = 5'd3; i_rs2 = 5'd3; i_rs1_used = 1'b1; i_rs2_used = 1'b1;
        i_issue_valid = 1'b1; i_issue_rd = 5'd3; i_issue_rd_we = 1'b1;
        #2;
        vectors++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset: got %b expected %b", obs, 7'b0);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        drain();
    endtask

    task automatic test_forward_alu2();
        vec_t s[$];
        s.push_back(mk(1, 2, 1, 1, 1, 5, 1, 0, 0, 0));   // add x5,x1,x2
        s.push_back(mk(5, 1, 1, 1, 1, 6, 1, 0, 0, 0));   // add x6,x5,x1
        s.push_back(idle());
        foreach (s[i]) begin
            apply(s[i]);
            vectors++;
            if (obs !== exp_all) begin
                errors++;
                $display("FAIL forward_alu2 step %0d: got %b expected %b", i, obs, exp_all);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_load_use();
        vec_t s[$];
        s.push_back(mk(1, 0, 1, 0, 1, 7, 1, 1, 0, 0));   // lw x7
        for (int i = 0; i < 4; i++) s.push_back(mk(7, 7, 1, 1, 1, 8, 1, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            vectors++;
            if (obs !== exp_all) begin
                errors++;
                $display("FAIL load_use step %0d: got %b expected %b", i, obs, exp_all);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_distance();
        vec_t s[$];
        s.push_back(mk(0, 0, 0, 0, 1, 9, 1, 0, 0, 0));   // producer x9
        s.push_back(mk(1, 2, 1, 1, 1, 10, 1, 0, 0, 0));
        s.push_back(mk(3, 4, 1, 1, 1, 11, 1, 0, 0, 0));
        s.push_back(mk(9, 1, 1, 1, 0, 12, 1, 0, 0, 0));  // x9 reader, not issuing: WR_BACK
        s.push_back(mk(9, 1, 1, 1, 1, 12, 1, 0, 0, 0));  // one gap later: gone
        s.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0));   // write x0
        s.push_back(mk(0, 0, 1, 1, 1, 5, 1, 0, 0, 0));   // read x0; also x5 producer
        s.push_back(mk(0, 0, 0, 0, 1, 5, 1, 0, 0, 0));   // x5 producer again
        s.push_back(mk(5, 5, 1, 1, 0, 0, 0, 0, 0, 0));   // x5 in ALU2 and WRITE
        foreach (s[i]) begin
            apply(s[i]);
            vectors++;
            if (obs !== exp_all) begin
                errors++;
                $display("FAIL distance step %0d: got %b expected %b", i, obs, exp_all);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_freeze_flush();
        vec_t s[$];
        s.push_back(mk(1, 0, 1, 0, 1, 7, 1, 1, 0, 0));   // lw x7
        for (int i = 0; i < 4; i++) s.push_back(mk(7, 7, 1, 1, 1, 8, 1, 0, 1, 0));
        for (int i = 0; i < 4; i++) s.push_back(mk(7, 7, 1, 1, 1, 8, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 10, 1, 0, 0, 1));  // flushed producer x10
        s.push_back(mk(10, 10, 1, 1, 1, 11, 1, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            vectors++;
            if (obs !== exp_all) begin
                errors++;
                $display("FAIL freeze_flush step %0d: got %b expected %b", i, obs, exp_all);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_stall_length();
        int n = 0;
        int want;
`ifdef RV_HAZARD_BYPASS_EN
        want = 0;
`else
        want = 3;
`endif
        apply(mk(1, 2, 1, 1, 1, 5, 1, 0, 0, 0));
        tick();
        for (int i = 0; i < 6; i++) begin
            apply(mk(5, 0, 1, 0, 1, 6, 1, 0, 0, 0));
            vectors++;
            if (obs !== exp_all) begin
                errors++;
                $display("FAIL stall_length cycle %0d: got %b expected %b", i, obs, exp_all);
            end
            if (o_stall !== 1'b1) begin
                tick();
                break;
            end
            n++;
            tick();
        end
        vectors++;
        if (n != want) begin
            errors++;
            $display("FAIL stall_length count: got %0d expected %0d", n, want);
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        apply(mk(1, 0, 1, 0, 1, 5, 1, 1, 0, 0));          // lw x5
        tick();
        apply(mk(5, 0, 1, 0, 1, 6, 1, 0, 0, 0));
        vectors++;
        if (obs !== exp_all) begin
            errors++;
            $display("FAIL reset_mid_stall pre: got %b expected %b", obs, exp_all);
        end
        #1 i_reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %b expected %b", obs, 7'b0);
        end
        model_clear();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        drain();
    endtask

    task automatic test_random();
        vec_t x;
        for (int i = 0; i < 600; i++) begin
            x.rs1 = int'($urandom_range(0, 7));
            x.rs2 = int'($urandom_range(0, 7));
            x.u1  = 1'($urandom_range(0, 3) != 0);
            x.u2  = 1'($urandom_range(0, 1));
            x.v   = 1'($urandom_range(0, 4) != 0);
            x.rd  = int'($urandom_range(0, 7));
            x.we  = 1'($urandom_range(0, 4) != 0);
            x.ld  = 1'($urandom_range(0, 2) == 0);
            x.ps  = 1'($urandom_range(0, 5) == 0);
            x.fl  = 1'($urandom_range(0, 9) == 0);
            apply(x);
            vectors++;
            if (obs !== exp_all) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", i, obs, exp_all);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward_alu2();
        test_load_use();
        test_distance();
        test_freeze_flush();
        test_stall_length();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
